// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_ctrl
//  Description : IF-stage fetch sequencer. Runs the instruction-memory
//                request/response handshake, generates the PC / IF-ID enable,
//                selects the next-PC source, absorbs ID back-pressure and
//                discards responses made stale by a redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             START,
   input  logic             STALL_ID,
   input  logic             REDIRECT_EXE,
   input  logic             PREDICT_TAKEN,
   input  logic             MEM_READY,
   input  logic             VALID,
   output logic             MEM_REQ,
   output logic             EN_IF,
   output logic             S0,
   output logic             S1,
   output logic             FLUSH_ID,
   output logic             BUSY,
   output logic             TIMEOUT_ERR,
   output logic [CNT_W-1:0] FETCH_CNT
);

   // Timer holds 0 .. TIMEOUT-1
   localparam int               TMR_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);

   localparam logic [1:0] C_SEL_SEQ  = 2'b00;
   localparam logic [1:0] C_SEL_PRED = 2'b01;
   localparam logic [1:0] C_SEL_EXE  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_KILL  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_req_q, mem_req_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;

   logic             redirect;
   logic             deliver;
   logic             expired;
   logic             en_if;
   logic             flush;
   logic [1:0]       sel;

   // Next-state, Mealy strobes and next values of the registered outputs
   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      redirect = 1'b0;
      deliver  = 1'b0;
      en_if    = 1'b0;
      flush    = 1'b0;
      sel      = C_SEL_SEQ;

      // A response that never arrives is fatal: the sequencer stops dead,
      // even if a redirect shows up in the same cycle.
      expired = ((state_q == ST_WAIT) || (state_q == ST_KILL)) &&
                !VALID && (tmr_q == C_TMR_LAST);

      if (expired) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (START && !err_q) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
               redirect = REDIRECT_EXE;
               // An accepted request launched under a redirect is already stale
               if (MEM_READY) state_d = REDIRECT_EXE ? ST_KILL : ST_WAIT;
            end
            ST_WAIT: begin
               if (REDIRECT_EXE) begin
                  redirect = 1'b1;
                  state_d  = VALID ? ST_ISSUE : ST_KILL;
               end else if (VALID) begin
                  if (!STALL_ID) begin
                     deliver = 1'b1;
                     state_d = ST_ISSUE;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (REDIRECT_EXE) begin
                  redirect = 1'b1;
                  state_d  = ST_ISSUE;
               end else if (!STALL_ID) begin
                  deliver = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
            ST_KILL: begin
               redirect = REDIRECT_EXE;
               if (VALID) state_d = ST_ISSUE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (redirect) begin
         en_if = 1'b1;
         flush = 1'b1;
         sel   = C_SEL_EXE;
      end else if (deliver) begin
         en_if = 1'b1;
         sel   = PREDICT_TAKEN ? C_SEL_PRED : C_SEL_SEQ;
      end

      cnt_d = deliver ? (cnt_q + CNT_W'(1)) : cnt_q;

      // Timer restarts on every entry to WAIT/KILL and counts while staying
      if (((state_d == ST_WAIT) || (state_d == ST_KILL)) && (state_d == state_q))
         tmr_d = tmr_q + TMR_W'(1);
      else
         tmr_d = '0;

      mem_req_d = (state_d == ST_ISSUE);
      busy_d    = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset abandons any outstanding response
   always_ff @(posedge CLK or posedge RSTn) begin
      if (RSTn) begin
         state_q   <= ST_IDLE;
         tmr_q     <= '0;
         cnt_q     <= '0;
         mem_req_q <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         cnt_q     <= cnt_d;
         mem_req_q <= mem_req_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign MEM_REQ     = mem_req_q;
   assign BUSY        = busy_q;
   assign TIMEOUT_ERR = err_q;
   assign FETCH_CNT   = cnt_q;
   assign EN_IF       = en_if;
   assign FLUSH_ID    = flush;
   assign S0          = sel[0];
   assign S1          = sel[1];

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_ctrl
//  Description : Self-checking bench for if_fetch_ctrl. A transaction-level
//                model (request / outstanding / stale / held flags) predicts
//                every output each cycle; a memory responder returns data a
//                programmable number of cycles after acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

   localparam int TMO   = 8;
   localparam int CNT_W = 6;

   logic             CLK = 1'b0;
   logic             RSTn = 1'b1;
   logic             START = 1'b0, STALL_ID = 1'b0, REDIRECT_EXE = 1'b0;
   logic             PREDICT_TAKEN = 1'b0, MEM_READY = 1'b0, VALID = 1'b0;
   logic             MEM_REQ, EN_IF, S0, S1, FLUSH_ID, BUSY, TIMEOUT_ERR;
   logic [CNT_W-1:0] FETCH_CNT;

   if_fetch_ctrl #(.TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RSTn(RSTn), .START(START), .STALL_ID(STALL_ID),
      .REDIRECT_EXE(REDIRECT_EXE), .PREDICT_TAKEN(PREDICT_TAKEN),
      .MEM_READY(MEM_READY), .VALID(VALID), .MEM_REQ(MEM_REQ), .EN_IF(EN_IF),
      .S0(S0), .S1(S1), .FLUSH_ID(FLUSH_ID), .BUSY(BUSY),
      .TIMEOUT_ERR(TIMEOUT_ERR), .FETCH_CNT(FETCH_CNT)
   );

   always #5 CLK = ~CLK;

   int n_cmp  = 0;
   int n_fail = 0;
   bit checking = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   bit m_run = 0, m_req = 0, m_out = 0, m_stale = 0, m_held = 0, m_err = 0;
   int m_wait = 0, m_cnt = 0;
   bit n_run, n_req, n_out, n_stale, n_held, n_err;
   int n_wait, n_cnt;
   bit e_en, e_flush;
   int e_sel;

   task automatic model_eval();
      bit dlv;
      dlv = 1'b0;
      e_en = 0; e_flush = 0; e_sel = 0;
      n_run = m_run; n_req = m_req; n_out = m_out; n_stale = m_stale;
      n_held = m_held; n_err = m_err; n_wait = m_wait; n_cnt = m_cnt;
      if (!m_run) begin
         if (START && !m_err) begin n_run = 1; n_req = 1; end
      end else if (m_out && !VALID && m_wait == TMO - 1) begin
         n_run = 0; n_req = 0; n_out = 0; n_stale = 0; n_err = 1; n_wait = 0;
      end else begin
         if (m_req) begin
            if (MEM_READY) begin
               n_req = 0; n_out = 1; n_stale = REDIRECT_EXE; n_wait = 0;
            end
         end else if (m_out) begin
            if (VALID) begin
               n_out = 0; n_stale = 0;
               if (m_stale || REDIRECT_EXE) n_req = 1;
               else if (!STALL_ID) begin dlv = 1; n_req = 1; end
               else n_held = 1;
            end else if (REDIRECT_EXE && !m_stale) begin
               n_stale = 1; n_wait = 0;
            end else begin
               n_wait = m_wait + 1;
            end
         end else if (m_held) begin
            if (REDIRECT_EXE) begin n_held = 0; n_req = 1; end
            else if (!STALL_ID) begin dlv = 1; n_held = 0; n_req = 1; end
         end
         if (REDIRECT_EXE) begin e_en = 1; e_flush = 1; e_sel = 2; end
         if (dlv) begin
            e_en  = 1;
            e_sel = PREDICT_TAKEN ? 1 : 0;
            n_cnt = (m_cnt + 1) % (1 << CNT_W);
         end
      end
   endtask

   // Model state advance (asynchronous reset like the DUT)
   initial begin
      forever begin
         @(posedge CLK or posedge RSTn);
         if (RSTn) begin
            m_run = 0; m_req = 0; m_out = 0; m_stale = 0; m_held = 0;
            m_err = 0; m_wait = 0; m_cnt = 0;
         end else begin
            model_eval();
            m_run = n_run; m_req = n_req; m_out = n_out; m_stale = n_stale;
            m_held = n_held; m_err = n_err; m_wait = n_wait; m_cnt = n_cnt;
         end
      end
   end

   // Per-cycle comparison away from the active edge
   initial begin
      forever begin
         @(negedge CLK);
         if (checking) begin
            model_eval();
            chk("MEM_REQ",     int'(MEM_REQ),     int'(m_req));
            chk("BUSY",        int'(BUSY),        int'(m_run));
            chk("TIMEOUT_ERR", int'(TIMEOUT_ERR), int'(m_err));
            chk("FETCH_CNT",   int'(FETCH_CNT),   m_cnt);
            chk("EN_IF",       int'(EN_IF),       int'(e_en));
            chk("SEL",         int'({S1, S0}),    e_sel);
            chk("FLUSH_ID",    int'(FLUSH_ID),    int'(e_flush));
         end
      end
   end

   // ---------------- stimulus / memory responder ----------------
   int p_ready = 100, p_stall = 0, p_pt = 0, p_redir = 0, p_start = 0;
   int lat_min = 0, lat_max = 0;
   bit start_force = 0, no_resp = 0;
   bit acc = 0, pend = 0;
   int lat = 0;

   task automatic step();
      @(posedge CLK);
      #1;
      if (acc) begin pend = 1; lat = $urandom_range(lat_max, lat_min); end
      VALID = 1'b0;
      if (pend && !no_resp) begin
         if (lat == 0) begin VALID = 1'b1; pend = 0; end
         else lat--;
      end
      MEM_READY     = ($urandom_range(99) < p_ready);
      STALL_ID      = ($urandom_range(99) < p_stall);
      PREDICT_TAKEN = ($urandom_range(99) < p_pt);
      REDIRECT_EXE  = ($urandom_range(99) < p_redir);
      START         = start_force || ($urandom_range(99) < p_start);
      acc           = MEM_REQ && MEM_READY;
   endtask

   task automatic reset_dut();
      RSTn = 1'b1;
      pend = 0; acc = 0;
      START = 0; STALL_ID = 0; REDIRECT_EXE = 0; PREDICT_TAKEN = 0;
      MEM_READY = 0; VALID = 0;
      repeat (2) @(posedge CLK);
      #1 RSTn = 1'b0;
   endtask

   task automatic knobs(input int rdy, input int stl, input int pt, input int rd, input int st);
      p_ready = rdy; p_stall = stl; p_pt = pt; p_redir = rd; p_start = st;
   endtask

   int en_seen, sel_nz;

   initial begin
      // Reset values
      repeat (2) @(posedge CLK);
      #1;
      chk("rst MEM_REQ",   int'(MEM_REQ), 0);
      chk("rst BUSY",      int'(BUSY), 0);
      chk("rst ERR",       int'(TIMEOUT_ERR), 0);
      chk("rst FETCH_CNT", int'(FETCH_CNT), 0);
      checking = 1'b1;
      RSTn = 1'b0;

      // Start latency, then steady stream of 10 fetches
      knobs(100, 0, 0, 0, 0); lat_min = 0; lat_max = 0;
      start_force = 1; step(); start_force = 0;
      step(); #1;
      chk("start MEM_REQ", int'(MEM_REQ), 1);
      chk("start BUSY",    int'(BUSY), 1);
      en_seen = 0; sel_nz = 0;
      for (int i = 0; i < 20; i++) begin
         step(); #1;
         en_seen += int'(EN_IF);
         if ({S1, S0} != 2'b00) sel_nz++;
      end
      chk("stream EN_IF pulses", en_seen, 10);
      chk("stream sel nonzero",  sel_nz, 0);
      chk("stream FETCH_CNT",    int'(FETCH_CNT), 10);

      // Back-pressure for 3 cycles, release with a predicted-taken delivery
      p_stall = 100; en_seen = 0;
      for (int i = 0; i < 3; i++) begin step(); #1; en_seen += int'(EN_IF); end
      chk("stall EN_IF pulses", en_seen, 0);
      p_stall = 0; p_pt = 100;
      step(); #1;
      chk("release EN_IF", int'(EN_IF), 1);
      chk("predict SEL",   int'({S1, S0}), 1);
      p_pt = 0;
      step(); #1;
      chk("after release MEM_REQ", int'(MEM_REQ), 1);

      // Redirect in WAIT with no response yet; stale response is dropped
      lat_min = 2; lat_max = 2; p_redir = 100;
      step(); #1;
      chk("wait redir EN_IF", int'(EN_IF), 1);
      chk("wait redir SEL",   int'({S1, S0}), 2);
      chk("wait redir FLUSH", int'(FLUSH_ID), 1);
      p_redir = 0;
      step();
      step(); #1;
      chk("stale VALID", int'(VALID), 1);
      chk("stale EN_IF", int'(EN_IF), 0);
      step(); #1;
      chk("post kill MEM_REQ",   int'(MEM_REQ), 1);
      chk("post kill FETCH_CNT", int'(FETCH_CNT), 11);

      // Redirect together with VALID in WAIT
      lat_min = 0; lat_max = 0; p_redir = 100;
      step(); #1;
      chk("redir+valid EN_IF", int'(EN_IF), 1);
      chk("redir+valid FLUSH", int'(FLUSH_ID), 1);
      p_redir = 0;
      step(); #1;
      chk("redir+valid MEM_REQ",   int'(MEM_REQ), 1);
      chk("redir+valid FETCH_CNT", int'(FETCH_CNT), 11);

      // Timeout: response never arrives
      reset_dut();
      no_resp = 1; knobs(100, 0, 0, 0, 0);
      start_force = 1; step(); start_force = 0;
      for (int i = 0; i < 9; i++) step();
      #1;
      chk("tmo last BUSY", int'(BUSY), 1);
      chk("tmo last ERR",  int'(TIMEOUT_ERR), 0);
      step(); #1;
      chk("tmo ERR",     int'(TIMEOUT_ERR), 1);
      chk("tmo BUSY",    int'(BUSY), 0);
      chk("tmo MEM_REQ", int'(MEM_REQ), 0);
      start_force = 1;
      repeat (3) step();
      start_force = 0;
      step(); #1;
      chk("tmo START ignored BUSY", int'(BUSY), 0);
      chk("tmo ERR sticky",         int'(TIMEOUT_ERR), 1);
      no_resp = 0;

      // Asynchronous reset in the middle of WAIT
      reset_dut();
      lat_min = 5; lat_max = 5; knobs(100, 0, 0, 0, 0);
      start_force = 1; step(); start_force = 0;
      step();
      p_redir = 100;
      step(); #1;
      chk("pre-reset EN_IF", int'(EN_IF), 1);
      RSTn = 1'b1;
      #1;
      chk("async rst EN_IF",   int'(EN_IF), 0);
      chk("async rst FLUSH",   int'(FLUSH_ID), 0);
      chk("async rst MEM_REQ", int'(MEM_REQ), 0);
      chk("async rst BUSY",    int'(BUSY), 0);
      p_redir = 0;

      // Randomized segments against the model
      for (int s = 0; s < 15; s++) begin
         reset_dut();
         knobs($urandom_range(100, 30), $urandom_range(60, 0), 50,
               $urandom_range(20, 0), 20);
         lat_min = 0;
         lat_max = (s % 3 == 0) ? 10 : 3;
         repeat (300) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch sequencer for the IF stage. It runs the instruction-memory request/response handshake, generates the PC-register and IF/ID enable `EN_IF`, and drives the PC source select `{S1,S0}`. It also handles ID back-pressure, applies EXE redirects and predictor redirects, and discards responses that become stale after a redirect. It sits beside the IF datapath, between the hazard/branch logic and the instruction memory port.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles a response may be outstanding before a fatal error is raised.
- `CNT_W`, 32: width of the delivered-instruction counter.

Ports:
- `CLK`, in, 1: the single clock; all state changes on its rising edge.
- `RSTn`, in, 1: reset, asynchronous, active-high (asserted = 1).
- `START`, in, 1: start fetching from the boot PC.
- `STALL_ID`, in, 1: ID cannot accept a new instruction this cycle.
- `REDIRECT_EXE`, in, 1: EXE misprediction; the PC must load `PC_EXE`.
- `PREDICT_TAKEN`, in, 1: predictor says the current fetch is taken; the next PC is `PC_PREDICT`.
- `MEM_READY`, in, 1: memory accepts the request this cycle.
- `VALID`, in, 1: memory returns `RDATA` this cycle.
- `MEM_REQ`, out, 1: read request; the address is the current PC.
- `EN_IF`, out, 1: advances the PC register and the IF/ID registers.
- `S0`, out, 1: PC select bit 0.
- `S1`, out, 1: PC select bit 1.
- `FLUSH_ID`, out, 1: marks the IF/ID contents written this cycle as a bubble.
- `BUSY`, out, 1: the FSM is not in IDLE.
- `TIMEOUT_ERR`, out, 1: sticky fatal flag.
- `FETCH_CNT`, out, `CNT_W`: count of instructions delivered to ID.

## Operation
- **PC select encoding.** `{S1,S0}` = 00 selects sequential PC+4, 01 selects `PC_PREDICT`, 10 selects `PC_EXE`. 11 is never driven. The value is 00 whenever `EN_IF` = 0.
- **FSM states.**
  - IDLE: `MEM_REQ` = 0, `EN_IF` = 0. `START` moves to ISSUE.
  - ISSUE: `MEM_REQ` = 1. The address is held stable because `EN_IF` = 0 unless there is a redirect.
    - `MEM_READY` = 1 moves to WAIT.
    - `REDIRECT_EXE` = 1 with `MEM_READY` = 0: `EN_IF` = 1, sel = 10, `FLUSH_ID` = 1, stay in ISSUE.
    - `REDIRECT_EXE` = 1 with `MEM_READY` = 1: same outputs, next state is KILL.
  - WAIT: `MEM_REQ` = 0. Priority is `REDIRECT_EXE` > `VALID`.
    - `REDIRECT_EXE` with `VALID`: `EN_IF`, sel = 10, `FLUSH_ID`, go to ISSUE (response discarded).
    - `REDIRECT_EXE` without `VALID`: `EN_IF`, sel = 10, `FLUSH_ID`, go to KILL.
    - `VALID` with `STALL_ID` = 0: `EN_IF` = 1, sel = 01 if `PREDICT_TAKEN` else 00, `FETCH_CNT` +1, go to ISSUE.
    - `VALID` with `STALL_ID` = 1: go to HOLD. The datapath holds `RDATA`.
  - HOLD: waits for ID to free up.
    - `REDIRECT_EXE`: `EN_IF`, sel = 10, `FLUSH_ID`, go to ISSUE (held instruction dropped).
    - `STALL_ID` = 0: `EN_IF` = 1, sel = 01/00 per `PREDICT_TAKEN`, `FETCH_CNT` +1, go to ISSUE.
  - KILL: a stale response is outstanding; `MEM_REQ` = 0.
    - `VALID` is discarded (`EN_IF` = 0), go to ISSUE.
    - `REDIRECT_EXE` in KILL: `EN_IF`, sel = 10, `FLUSH_ID`, stay in KILL.
- **Timeout.** A cycle counter clears on entry to WAIT or KILL and counts each cycle there without `VALID`. When it reaches `TIMEOUT`-1, set `TIMEOUT_ERR` (sticky until reset) and move to IDLE. `START` is ignored while `TIMEOUT_ERR` = 1.
- **Other outputs.**
  - `BUSY` = (state != IDLE).
  - `FETCH_CNT` wraps modulo 2^`CNT_W`.
- **Input-ignore rules.**
  - `STALL_ID` and `PREDICT_TAKEN` are ignored except in WAIT/HOLD delivery cycles.
  - `START` is ignored when not in IDLE.

## Timing
- `MEM_REQ`, `BUSY` and `TIMEOUT_ERR` are registered, Moore-style.
- `EN_IF`, `S0`, `S1` and `FLUSH_ID` are combinational from state and the current-cycle inputs. They assert in the same cycle as the triggering `VALID`/`REDIRECT_EXE`.
- **Reset.** While `RSTn` = 1, state is IDLE and every output is 0, including `FETCH_CNT` and the timeout counter, independent of `CLK`. A reset mid-transaction abandons the outstanding response. The memory is reset by the same signal.
- **Start latency.** `START` high in cycle 0 gives `MEM_REQ` high in cycle 1.
- **Throughput.** With `MEM_READY` = 1 and `VALID` one cycle after acceptance, there is one instruction per 2 cycles: ISSUE, WAIT+deliver, ISSUE, ...
- **Redirect latency.** A redirect loads the PC at the next edge. The first fetch from the new PC is requested at most 1 cycle later, or after the stale `VALID` if in KILL.
- At most one request is outstanding at any time.

## Test plan
- **Reset/start.** Assert `RSTn` mid-WAIT → all outputs 0 immediately. `START`=1 in cycle 0 → `MEM_REQ`=1 in cycle 1, `BUSY`=1.
- **Steady stream.** `MEM_READY`=1, `VALID` 1 cycle after acceptance, 10 fetches → `EN_IF` pulses every 2 cycles, sel=00, `FETCH_CNT`=10.
- **Back-pressure.** `VALID` with `STALL_ID`=1 for 3 cycles → no `EN_IF` for 3 cycles. `EN_IF`=1 in the cycle `STALL_ID` drops, then the next `MEM_REQ`.
- **Predict.** `VALID` with `PREDICT_TAKEN`=1 → `EN_IF`=1, `{S1,S0}`=01 in the same cycle.
- **Redirect after accept.** `REDIRECT_EXE` in WAIT, no `VALID` → `EN_IF`=1, sel=10, `FLUSH_ID`=1. The later `VALID` is dropped (`EN_IF`=0, count unchanged), then `MEM_REQ`=1. `REDIRECT_EXE` together with `VALID` in WAIT → response dropped, next state ISSUE.
- **Timeout.** `TIMEOUT`=8, `VALID` never arrives → `TIMEOUT_ERR`=1 after 8 cycles in WAIT, `BUSY`=0. `START` is then ignored until reset.
